// File: rtl/mem_arbiter_pkg.sv
// Shared types, widths and helpers for the byte-wide RAM port arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ROBBW = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNTW  = 3;

    localparam logic [1:0] MEMW_B = 2'b00;
    localparam logic [1:0] MEMW_H = 2'b01;
    localparam logic [1:0] MEMW_W = 2'b10;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_RD = 3'd1,
        ST_LS_RD = 3'd2,
        ST_LS_WR = 3'd3,
        ST_COOL  = 3'd4
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_LSB = 1'b1
    } grant_e;

    // Byte count for an LSB width code; the reserved code behaves as a word.
    function automatic logic [CNTW-1:0] width_bytes(input logic [1:0] w);
        case (w)
            MEMW_B:  return CNTW'(1);
            MEMW_H:  return CNTW'(2);
            default: return CNTW'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// load/store buffer, sequencing each request as little-endian byte transfers.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 if_req_flag,
    input  logic [AW-1:0]        if_req_addr,
    output logic                 if_done_flag,
    output logic [DW-1:0]        if_data,
    input  logic                 lsb_req_flag,
    input  logic [1:0]           lsb_req_width,
    input  logic                 lsb_req_type,
    input  logic                 lsb_req_signed,
    input  logic [AW-1:0]        lsb_req_addr,
    input  logic [DW-1:0]        lsb_req_data,
    input  logic [ROBBW-1:0]     lsb_req_rob_id,
    output logic                 lsb_done_flag,
    output logic                 ld_cdb_flag,
    output logic [ROBBW-1:0]     ld_cdb_rob_id,
    output logic [DW-1:0]        ld_cdb_val,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [AW-1:0]        mem_a,
    output logic                 mem_wr
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   n_q, n_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     asm_q, asm_d;
    logic              sgn_q, sgn_d;
    logic [ROBBW-1:0]  rob_q, rob_d;

    logic              if_done_q, if_done_d;
    logic [DW-1:0]     if_data_q, if_data_d;
    logic              lsb_done_q, lsb_done_d;
    logic              cdb_flag_q, cdb_flag_d;
    logic [ROBBW-1:0]  cdb_rob_q, cdb_rob_d;
    logic [DW-1:0]     cdb_val_q, cdb_val_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic [AW-1:0]     mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;

    logic [CNTW-1:0]   nxt_idx_c;
    logic [1:0]        rd_idx_c;
    logic [DW-1:0]     asm_next_c;
    logic [DW-1:0]     load_val_c;
    logic              grant_lsb_c;

    assign nxt_idx_c   = cnt_q + CNTW'(1);
    assign rd_idx_c    = 2'(cnt_q - CNTW'(1));
    assign grant_lsb_c = lsb_req_flag && (!if_req_flag || last_grant_q == GNT_IF);

    // Merge the byte arriving this edge into its lane, then extend for loads.
    always_comb begin
        asm_next_c = asm_q;
        asm_next_c[{rd_idx_c, 3'b000} +: 8] = mem_din;
        case (n_q)
            CNTW'(1): load_val_c = {{24{sgn_q & asm_next_c[7]}},  asm_next_c[7:0]};
            CNTW'(2): load_val_c = {{16{sgn_q & asm_next_c[15]}}, asm_next_c[15:0]};
            default:  load_val_c = asm_next_c;
        endcase
    end

    // Next-state, grant, byte sequencing and completion pulses.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        addr_d       = addr_q;
        data_d       = data_q;
        asm_d        = asm_q;
        sgn_d        = sgn_q;
        rob_d        = rob_q;
        if_done_d    = FALSE;
        if_data_d    = if_data_q;
        lsb_done_d   = FALSE;
        cdb_flag_d   = FALSE;
        cdb_rob_d    = cdb_rob_q;
        cdb_val_d    = cdb_val_q;
        mem_dout_d   = mem_dout_q;
        mem_a_d      = mem_a_q;
        mem_wr_d     = mem_wr_q;

        case (state_q)
            ST_IDLE: begin
                mem_wr_d = FALSE;
                mem_a_d  = '0;
                cnt_d    = '0;
                asm_d    = '0;
                if (!clr) begin
                    if (grant_lsb_c) begin
                        last_grant_d = GNT_LSB;
                        addr_d       = lsb_req_addr;
                        n_d          = width_bytes(lsb_req_width);
                        sgn_d        = lsb_req_signed;
                        data_d       = lsb_req_data;
                        rob_d        = lsb_req_rob_id;
                        mem_a_d      = lsb_req_addr;
                        if (lsb_req_type) begin
                            state_d    = ST_LS_WR;
                            mem_wr_d   = TRUE;
                            mem_dout_d = lsb_req_data[7:0];
                        end else begin
                            state_d = ST_LS_RD;
                        end
                    end else if (if_req_flag) begin
                        last_grant_d = GNT_IF;
                        addr_d       = if_req_addr;
                        n_d          = CNTW'(4);
                        mem_a_d      = if_req_addr;
                        state_d      = ST_IF_RD;
                    end
                end
            end

            ST_IF_RD, ST_LS_RD: begin
                if (clr) begin
                    state_d  = ST_IDLE;
                    mem_a_d  = '0;
                    mem_wr_d = FALSE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = nxt_idx_c;
                    if (cnt_q != '0) asm_d = asm_next_c;
                    if (nxt_idx_c < n_q) mem_a_d = addr_q + AW'(nxt_idx_c);
                    if (cnt_q == n_q) begin
                        state_d = ST_COOL;
                        cnt_d   = '0;
                        mem_a_d = '0;
                        if (state_q == ST_IF_RD) begin
                            if_done_d = TRUE;
                            if_data_d = asm_next_c;
                        end else begin
                            lsb_done_d = TRUE;
                            cdb_flag_d = TRUE;
                            cdb_rob_d  = rob_q;
                            cdb_val_d  = load_val_c;
                        end
                    end
                end
            end

            // Committed stores always finish, so rollback is not observed here.
            ST_LS_WR: begin
                cnt_d = nxt_idx_c;
                if (nxt_idx_c < n_q) begin
                    mem_a_d    = addr_q + AW'(nxt_idx_c);
                    mem_dout_d = data_q[{nxt_idx_c[1:0], 3'b000} +: 8];
                end else begin
                    state_d    = ST_COOL;
                    cnt_d      = '0;
                    mem_wr_d   = FALSE;
                    mem_a_d    = '0;
                    lsb_done_d = TRUE;
                end
            end

            ST_COOL: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; rdy low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_IF;
            cnt_q        <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            asm_q        <= '0;
            sgn_q        <= FALSE;
            rob_q        <= '0;
            if_done_q    <= FALSE;
            if_data_q    <= '0;
            lsb_done_q   <= FALSE;
            cdb_flag_q   <= FALSE;
            cdb_rob_q    <= '0;
            cdb_val_q    <= '0;
            mem_dout_q   <= '0;
            mem_a_q      <= '0;
            mem_wr_q     <= FALSE;
        end else if (rdy) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            asm_q        <= asm_d;
            sgn_q        <= sgn_d;
            rob_q        <= rob_d;
            if_done_q    <= if_done_d;
            if_data_q    <= if_data_d;
            lsb_done_q   <= lsb_done_d;
            cdb_flag_q   <= cdb_flag_d;
            cdb_rob_q    <= cdb_rob_d;
            cdb_val_q    <= cdb_val_d;
            mem_dout_q   <= mem_dout_d;
            mem_a_q      <= mem_a_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign if_done_flag  = if_done_q;
    assign if_data       = if_data_q;
    assign lsb_done_flag = lsb_done_q;
    assign ld_cdb_flag   = cdb_flag_q;
    assign ld_cdb_rob_id = cdb_rob_q;
    assign ld_cdb_val    = cdb_val_q;
    assign mem_dout      = mem_dout_q;
    assign mem_a         = mem_a_q;
    assign mem_wr        = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each
// completion (value, tag, cycle, write count); a monitor checks them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst, rdy, clr;
    logic              if_req_flag;
    logic [31:0]       if_req_addr;
    logic              if_done_flag;
    logic [31:0]       if_data;
    logic              lsb_req_flag;
    logic [1:0]        lsb_req_width;
    logic              lsb_req_type, lsb_req_signed;
    logic [31:0]       lsb_req_addr, lsb_req_data;
    logic [ROBBW-1:0]  lsb_req_rob_id;
    logic              lsb_done_flag, ld_cdb_flag;
    logic [ROBBW-1:0]  ld_cdb_rob_id;
    logic [31:0]       ld_cdb_val;
    logic [7:0]        mem_din, mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .if_req_flag(if_req_flag), .if_req_addr(if_req_addr),
        .if_done_flag(if_done_flag), .if_data(if_data),
        .lsb_req_flag(lsb_req_flag), .lsb_req_width(lsb_req_width),
        .lsb_req_type(lsb_req_type), .lsb_req_signed(lsb_req_signed),
        .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
        .lsb_req_rob_id(lsb_req_rob_id), .lsb_done_flag(lsb_done_flag),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id),
        .ld_cdb_val(ld_cdb_val), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: 8 KiB mirror of the address space, one-edge read latency.
    logic [7:0] ram [0:8191];
    initial begin
        mem_din = 8'h00;
        for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
        ram[13'h1000] = 8'h13; ram[13'h1001] = 8'h05;
        ram[13'h1002] = 8'h00; ram[13'h1003] = 8'h00;
        ram[13'h0020] = 8'h80;
        ram[13'h0102] = 8'h5A;
        forever begin
            @(posedge clk);
            if (mem_wr) ram[mem_a[12:0]] = mem_dout;
            mem_din <= ram[mem_a[12:0]];
        end
    end

    typedef struct { logic [31:0] data; int cyc; } if_exp_t;
    typedef struct {
        logic             is_load;
        logic [ROBBW-1:0] rob;
        logic [31:0]      val;
        int               cyc;
        int               nwr;
    } ls_exp_t;
    typedef struct {
        bit               is_if;
        bit               st;
        logic [1:0]       w;
        bit               sgn;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [ROBBW-1:0] rob;
    } txn_t;

    // Stimulus-owned state
    if_exp_t    if_exp [0:255];
    ls_exp_t    ls_exp [0:255];
    int         if_wp = 0, ls_wp = 0;
    int         zreq = 0, zmode = 0, to_req = 0, fin_req = 0;
    logic [7:0] ref_ram [0:8191];
    bit         last_lsb = 1'b0;

    // Monitor-owned state
    int n_cmp = 0, n_bad = 0;
    int if_rp = 0, ls_rp = 0;
    int zack = 0, to_ack = 0, fin_ack = 0, wcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every completion and requested snapshot with the model.
    always @(negedge clk) begin
        if (rst) wcnt = 0;
        else if (mem_wr && rdy) wcnt++;
        if (zreq != zack) begin
            zack = zreq;
            chk("out_mem_a", mem_a, 32'h0);
            chk("out_mem_wr", 32'(mem_wr), 32'h0);
            chk("out_if_done", 32'(if_done_flag), 32'h0);
            chk("out_lsb_done", 32'(lsb_done_flag), 32'h0);
            chk("out_cdb_flag", 32'(ld_cdb_flag), 32'h0);
            if (zmode == 1) begin
                chk("rst_if_data", if_data, 32'h0);
                chk("rst_cdb_val", ld_cdb_val, 32'h0);
                chk("rst_cdb_rob", 32'(ld_cdb_rob_id), 32'h0);
                chk("rst_mem_dout", 32'(mem_dout), 32'h0);
            end
        end
        if (to_req != to_ack) begin
            to_ack = to_req;
            n_cmp++; n_bad++;
            $display("FAIL timeout: got no completion, want completion (cycle %0d)", cyc);
        end
        if (if_done_flag) begin
            if (if_rp == if_wp) begin
                n_cmp++; n_bad++;
                $display("FAIL if_done_unexpected: got pulse want none (cycle %0d)", cyc);
            end else begin
                chk("if_data", if_data, if_exp[if_rp & 255].data);
                chk("if_done_cycle", 32'(cyc), 32'(if_exp[if_rp & 255].cyc));
                chk("if_mem_wr_cycles", 32'(wcnt), 32'h0);
                if_rp++;
            end
            wcnt = 0;
        end
        if (lsb_done_flag) begin
            if (ls_rp == ls_wp) begin
                n_cmp++; n_bad++;
                $display("FAIL lsb_done_unexpected: got pulse want none (cycle %0d)", cyc);
            end else begin
                chk("ld_cdb_flag", 32'(ld_cdb_flag), 32'(ls_exp[ls_rp & 255].is_load));
                if (ls_exp[ls_rp & 255].is_load) begin
                    chk("ld_cdb_rob_id", 32'(ld_cdb_rob_id), 32'(ls_exp[ls_rp & 255].rob));
                    chk("ld_cdb_val", ld_cdb_val, ls_exp[ls_rp & 255].val);
                end
                chk("lsb_done_cycle", 32'(cyc), 32'(ls_exp[ls_rp & 255].cyc));
                chk("lsb_mem_wr_cycles", 32'(wcnt), 32'(ls_exp[ls_rp & 255].nwr));
                ls_rp++;
            end
            wcnt = 0;
        end
        if (ld_cdb_flag && !lsb_done_flag) begin
            n_cmp++; n_bad++;
            $display("FAIL cdb_without_done: got cdb pulse want lsb_done with it (cycle %0d)", cyc);
        end
        if (fin_req != fin_ack) begin
            int bad;
            bad = 0;
            for (int i = 0; i < 8192; i++) if (ram[i] !== ref_ram[i]) bad++;
            chk("ram_bytes_differing", 32'(bad), 32'h0);
            chk("if_outstanding", 32'(if_wp - if_rp), 32'h0);
            chk("lsb_outstanding", 32'(ls_wp - ls_rp), 32'h0);
            fin_ack = fin_req;
        end
    end

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
        logic [31:0] v;
        logic [31:0] ak;
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v = v | (32'(ref_ram[ak[12:0]]) << (8 * k));
        end
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic int lat(input txn_t t);
        if (t.is_if) return 5;
        return t.st ? nbytes(t.w) : nbytes(t.w) + 1;
    endfunction

    task automatic drive(input txn_t t);
        if (t.is_if) begin
            if_req_flag = 1'b1;
            if_req_addr = t.addr;
        end else begin
            lsb_req_flag   = 1'b1;
            lsb_req_width  = t.w;
            lsb_req_type   = t.st;
            lsb_req_signed = t.sgn;
            lsb_req_addr   = t.addr;
            lsb_req_data   = t.data;
            lsb_req_rob_id = t.rob;
        end
    endtask

    // Model one served transaction: push its expectation and apply any store.
    task automatic expect_txn(input txn_t t, input int done_cyc);
        logic [31:0] ak;
        int n;
        n = nbytes(t.w);
        if (t.is_if) begin
            if_exp[if_wp & 255].data = model_load(t.addr, 4, 1'b0);
            if_exp[if_wp & 255].cyc  = done_cyc;
            if_wp++;
        end else begin
            ls_exp[ls_wp & 255].is_load = !t.st;
            ls_exp[ls_wp & 255].rob     = t.rob;
            ls_exp[ls_wp & 255].val     = t.st ? 32'h0 : model_load(t.addr, n, t.sgn);
            ls_exp[ls_wp & 255].cyc     = done_cyc;
            ls_exp[ls_wp & 255].nwr     = t.st ? n : 0;
            ls_wp++;
            if (t.st) begin
                for (int k = 0; k < n; k++) begin
                    ak = t.addr + 32'(k);
                    ref_ram[ak[12:0]] = t.data[8*k +: 8];
                end
            end
        end
        last_lsb = !t.is_if;
    endtask

    // Hold requests until their done pulses, then step past the cool-down.
    task automatic wait_done(input int n_exp);
        int seen, budget;
        seen = 0; budget = 80;
        while (seen < n_exp && budget > 0) begin
            @(negedge clk);
            budget--;
            if (if_done_flag)  begin if_req_flag  = 1'b0; seen++; end
            if (lsb_done_flag) begin lsb_req_flag = 1'b0; seen++; end
        end
        if (seen < n_exp) begin
            to_req++;
            if_req_flag = 1'b0; lsb_req_flag = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_single(input txn_t t);
        drive(t);
        expect_txn(t, cyc + 1 + lat(t));
        wait_done(1);
    endtask

    task automatic run_tie(input txn_t ti, input txn_t tl);
        txn_t f, s;
        int d1;
        drive(ti); drive(tl);
        if (!last_lsb) begin f = tl; s = ti; end
        else           begin f = ti; s = tl; end
        d1 = cyc + 1 + lat(f);
        expect_txn(f, d1);
        expect_txn(s, d1 + 2 + lat(s));
        wait_done(2);
    endtask

    function automatic txn_t mk(input bit is_if, input bit st, input logic [1:0] w,
                                input bit sgn, input logic [31:0] a, input logic [31:0] d,
                                input int rob);
        txn_t t;
        t.is_if = is_if; t.st = st; t.w = w; t.sgn = sgn;
        t.addr = a; t.data = d; t.rob = ROBBW'(rob);
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_if);
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
        else                           a = 32'($urandom_range(0, 8191));
        return mk(is_if, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, 32'($urandom), int'($urandom_range(0, 15)));
    endfunction

    initial begin
        txn_t t;
        int   b;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        if_req_flag = 1'b0; if_req_addr = 32'h0;
        lsb_req_flag = 1'b0; lsb_req_width = 2'b00; lsb_req_type = 1'b0;
        lsb_req_signed = 1'b0; lsb_req_addr = 32'h0; lsb_req_data = 32'h0;
        lsb_req_rob_id = '0;
        repeat (3) @(posedge clk);
        #1 zmode = 1; zreq++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8192; i++) ref_ram[i] = ram[i];
        @(posedge clk); #1;

        // Directed: fetch, signed/unsigned byte loads, halfword store
        run_single(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0));
        run_single(mk(1'b0, 1'b0, MEMW_B, 1'b1, 32'h0000_0020, 32'h0, 5));
        run_single(mk(1'b0, 1'b0, MEMW_B, 1'b0, 32'h0000_0020, 32'h0, 6));
        run_single(mk(1'b0, 1'b1, MEMW_H, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 7));

        // Both requesters held: LSB wins a tie after an IF grant
        run_tie(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0),
                mk(1'b0, 1'b0, MEMW_W, 1'b0, 32'h0000_0100, 32'h0, 9));
        run_tie(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0),
                mk(1'b0, 1'b0, MEMW_H, 1'b1, 32'h0000_0100, 32'h0, 10));

        // Rollback during fetch byte 2: aborted, arbiter idle next edge
        t = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 0);
        drive(t);
        last_lsb = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clr = 1'b1; if_req_flag = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0; zmode = 0; zreq++;
        run_single(mk(1'b0, 1'b0, MEMW_W, 1'b0, 32'h0000_0400, 32'h0, 3));

        // Rollback during a word store is ignored
        t = mk(1'b0, 1'b1, MEMW_W, 1'b0, 32'h0000_0200, 32'h1234_5678, 4);
        drive(t);
        expect_txn(t, cyc + 1 + lat(t));
        repeat (2) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_done(1);

        // rdy low for three edges mid-store stretches it by three cycles
        t = mk(1'b0, 1'b1, MEMW_W, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 2);
        drive(t);
        expect_txn(t, cyc + 1 + lat(t) + 3);
        repeat (2) begin @(posedge clk); #1; end
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        wait_done(1);

        // Randomized mix of singles and ties
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       run_single(rand_txn(1'b1));
                1:       run_single(rand_txn(1'b0));
                default: run_tie(rand_txn(1'b1), rand_txn(1'b0));
            endcase
        end

        // Asynchronous reset in the middle of a word store
        t = mk(1'b0, 1'b1, MEMW_W, 1'b0, 32'h0000_0500, 32'hA1B2_C3D4, 1);
        drive(t);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; lsb_req_flag = 1'b0;
        zmode = 1; zreq++;
        ref_ram[13'h0500] = 8'hD4;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_lsb = 1'b0;
        run_tie(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0),
                mk(1'b0, 1'b0, MEMW_B, 1'b1, 32'h0000_0020, 32'h0, 11));

        fin_req++;
        b = 0;
        while (fin_ack != fin_req && b < 20) begin @(posedge clk); b++; end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
